// File: rtl/op_requester_pkg.sv
// Shared types and helpers for the per-lane operand requester.
// Also provides the VRF address and queue-source mapping used elsewhere in the lane.
package op_requester_pkg;

    localparam int NrOpQueue        = 3;
    localparam int RegSliceNumWords = 8;
    localparam int NrVRegs          = 32;
    localparam int VRegW            = $clog2(NrVRegs);
    localparam int VrfAddrW         = $clog2(NrVRegs * RegSliceNumWords);
    localparam int MaxAccCnt        = RegSliceNumWords * 8;
    localparam int AccCntW          = $clog2(MaxAccCnt + 1);

    typedef logic [VRegW-1:0]    vreg_t;
    typedef logic [VrfAddrW-1:0] vrf_addr_t;
    typedef logic [AccCntW-1:0]  acc_cnt_t;

    typedef enum logic [1:0] {
        ALUA    = 2'd0,
        ALUB    = 2'd1,
        StoreOp = 2'd2
    } op_queue_e;

    typedef enum logic {
        SrcVs1,
        SrcVs2
    } op_src_e;

    typedef struct packed {
        vreg_t                  vs1;
        vreg_t                  vs2;
        logic [NrOpQueue-1:0]   queue_req;
        acc_cnt_t               acc_cnt;
    } op_req_t;

    typedef struct packed {
        vrf_addr_t addr;
        op_queue_e queue;
    } op_rd_req_t;

    function automatic vrf_addr_t GetVRFAddr(vreg_t r);
        return vrf_addr_t'(r) * vrf_addr_t'(RegSliceNumWords);
    endfunction

    // The dispatcher places store data in vs1, so only ALUB reads vs2.
    function automatic op_src_e GetOpSrcReg(op_queue_e q);
        case (q)
            ALUB:    return SrcVs2;
            default: return SrcVs1;
        endcase
    endfunction

endpackage

// File: rtl/op_requester_if.sv
// Request and VRF-read bundle between sequencer, operand queues, bank arbiter and requester.
// master drives requests/readiness/grants; slave is the requester.
interface op_requester_if;
    import op_requester_pkg::*;

    logic                   op_req_valid_i;
    op_req_t                op_req_i;
    logic                   op_req_ready_o;
    logic [NrOpQueue-1:0]   queue_ready_i;
    logic                   rd_req_o;
    vrf_addr_t              rd_addr_o;
    op_queue_e              rd_queue_o;
    logic                   rd_gnt_i;
    logic                   op_done_o;

    modport master (
        output op_req_valid_i, op_req_i, queue_ready_i, rd_gnt_i,
        input  op_req_ready_o, rd_req_o, rd_addr_o, rd_queue_o, op_done_o
    );

    modport slave (
        input  op_req_valid_i, op_req_i, queue_ready_i, rd_gnt_i,
        output op_req_ready_o, rd_req_o, rd_addr_o, rd_queue_o, op_done_o
    );

endinterface

// File: rtl/op_requester_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer advances past an accepted winner.
// Kept generic so the bank arbiter can reuse it.
module op_requester_rr_arbiter #(
    parameter  int N    = 3,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic            i_gnt_accept,
    output logic [N-1:0]    o_gnt,
    output logic [IdxW-1:0] o_idx,
    output logic            o_valid
);

    // r_ptr is the first requester considered, i.e. the one after the last accepted winner.
    logic [IdxW-1:0] r_ptr;

    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!o_valid && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_idx    = IdxW'(j);
                o_valid  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_gnt_accept && o_valid) begin
            r_ptr <= (o_idx == IdxW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/op_requester.sv
// Per-lane operand requester: walks the source registers of one request word by word,
// issuing one tagged VRF read per cycle to whichever operand queue has space.
module op_requester
    import op_requester_pkg::*;
#(
    parameter int NrQueues = NrOpQueue,
    parameter int RegWords = RegSliceNumWords
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    op_requester_if.slave   bus
);

    localparam int SelW = $clog2(NrQueues);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    acc_cnt_t           r_pend [NrQueues];
    acc_cnt_t           r_idx  [NrQueues];
    vrf_addr_t          r_base [NrQueues];
    logic               r_done;

    logic [NrQueues-1:0] w_elig;
    logic [NrQueues-1:0] w_gnt;
    logic [SelW-1:0]     w_sel;
    logic                w_any;
    logic                w_xfer;
    logic                w_accept;
    logic                w_empty_req;
    logic                w_others;
    logic                w_last;
    op_rd_req_t          w_rd;

    always_comb begin
        w_elig = '0;
        for (int q = 0; q < NrQueues; q++) begin
            w_elig[q] = (r_state == BUSY) && (r_pend[q] != '0) && bus.queue_ready_i[q];
        end
    end

    op_requester_rr_arbiter #(
        .N(NrQueues)
    ) u_arb (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_req        (w_elig),
        .i_gnt_accept (w_xfer),
        .o_gnt        (w_gnt),
        .o_idx        (w_sel),
        .o_valid      (w_any)
    );

    assign w_xfer = w_any & bus.rd_gnt_i;

    // Only one queue decrements per cycle, so the request finishes when the winner
    // sends its final word and nobody else still has words pending.
    always_comb begin
        w_others = 1'b0;
        for (int q = 0; q < NrQueues; q++) begin
            if (!w_gnt[q] && (r_pend[q] != '0)) begin
                w_others = 1'b1;
            end
        end
    end

    assign w_last = w_xfer && (r_pend[w_sel] == acc_cnt_t'(1)) && !w_others;

    always_comb begin
        w_rd.addr  = '0;
        w_rd.queue = ALUA;
        if (w_any) begin
            w_rd.addr  = r_base[w_sel] + vrf_addr_t'(r_idx[w_sel]);
            w_rd.queue = op_queue_e'(w_sel);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_empty_req = (bus.op_req_i.acc_cnt == '0) || (bus.op_req_i.queue_req == '0);
        case (r_state)
            IDLE: begin
                if (bus.op_req_valid_i) begin
                    w_accept = 1'b1;
                    if (!w_empty_req) begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            for (int q = 0; q < NrQueues; q++) begin
                r_pend[q] <= '0;
                r_idx[q]  <= '0;
                r_base[q] <= '0;
            end
        end else begin
            r_done <= (w_accept && w_empty_req) || w_last;
            if (w_accept) begin
                for (int q = 0; q < NrQueues; q++) begin
                    r_pend[q] <= bus.op_req_i.queue_req[q] ? bus.op_req_i.acc_cnt : '0;
                    r_idx[q]  <= '0;
                    r_base[q] <= GetVRFAddr(
                        (GetOpSrcReg(op_queue_e'(SelW'(q))) == SrcVs2) ? bus.op_req_i.vs2
                                                                        : bus.op_req_i.vs1);
                end
            end else if (w_xfer) begin
                for (int q = 0; q < NrQueues; q++) begin
                    if (w_gnt[q]) begin
                        r_pend[q] <= r_pend[q] - 1'b1;
                        r_idx[q]  <= r_idx[q] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.op_req_ready_o = (r_state == IDLE);
    assign bus.rd_req_o       = w_any;
    assign bus.rd_addr_o      = w_rd.addr;
    assign bus.rd_queue_o     = w_rd.queue;
    assign bus.op_done_o      = r_done;

    // Word index must stay within an LMUL-8 register group.
    a_acc_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_accept && (bus.op_req_i.queue_req != '0)) |->
            (bus.op_req_i.acc_cnt <= acc_cnt_t'(RegWords * 8)));

endmodule

// File: doc/op_requester.md
Name: op_requester

Overview:
- Per-lane operand requester between the lane sequencer and the VRF bank arbiter.
- Accepts one operand request at a time (vs1, vs2, per-queue request mask, access count).
- Walks the source registers word by word and issues one VRF read per cycle.
- Tags each read with its destination operand queue (ALUA, ALUB, StoreOp) and signals completion when all enabled queues have been served.

Parameters:
- NrQueues, core_pkg::NrOpQueue (3): number of operand queues served.
- RegWords, core_pkg::RegSliceNumWords: VRF words per register slice per lane; bounds the word index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- op_req_valid_i  in  1  new operand request valid
- op_req_i  in  $bits(op_req_t)  vs1, vs2, queue_req, acc_cnt
- op_req_ready_o  out  1  requester idle, can accept
- queue_ready_i  in  NrQueues  destination operand queue has space for one word
- rd_req_o  out  1  VRF read request valid
- rd_addr_o  out  $bits(vrf_addr_t)  VRF slice word address
- rd_queue_o  out  $bits(op_queue_e)  destination queue tag for the read
- rd_gnt_i  in  1  bank arbiter accepted the current read
- op_done_o  out  1  one-cycle pulse: all words of the current request issued

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - FSM goes to IDLE; all counters are cleared; the round-robin pointer is set to queue 0.
  - Outputs: op_req_ready_o=1, rd_req_o=0, op_done_o=0, rd_addr_o=0, rd_queue_o=ALUA.
- Reset mid-operation drops the in-flight request with no done pulse.
- FSM states: IDLE, BUSY.
- IDLE:
  - op_req_ready_o=1.
  - On op_req_valid_i, latch the request. For each q with queue_req[q]=1, set pend[q]=acc_cnt and idx[q]=0.
  - Source register: ALUA reads vs1, ALUB reads vs2, StoreOp reads vs1 (the dispatcher places the store data register in vs1).
  - If acc_cnt==0 or queue_req==0: stay IDLE and pulse op_done_o in the next cycle.
  - Otherwise go to BUSY in the next cycle.
- BUSY:
  - op_req_ready_o=0.
  - Eligible queue: pend[q]!=0 and queue_ready_i[q]=1.
  - A round-robin arbiter picks one eligible queue, starting after the last granted queue.
  - rd_req_o=1 iff at least one queue is eligible.
  - rd_addr_o = GetVRFAddr(src[q]) + idx[q], with unsigned wrap at vrf_addr_t width.
  - rd_queue_o = q.
- Handshake:
  - A read transfers on rd_req_o & rd_gnt_i.
  - On transfer: pend[q]-1, idx[q]+1, and the round-robin pointer moves to q.
  - Without a grant, the arbiter may re-pick next cycle. Address and tag need only be stable while the selected queue stays eligible; rd_req_o/rd_addr_o/rd_queue_o depend combinationally on queue_ready_i.
- Completion:
  - When the transfer makes the sum of all pend equal zero, op_done_o pulses in the following cycle, the FSM returns to IDLE, and op_req_ready_o=1 in that same cycle.
  - A new request accepted in that cycle is legal (back-to-back requests).
- Throughput: at most one read per cycle; a single enabled queue with constant grant and ready issues acc_cnt reads in acc_cnt consecutive cycles.
- Latency: accept at edge N; the first rd_req_o is possible in cycle N+1.
- A queue whose queue_ready_i deasserts is skipped while others proceed. When every pending queue is not ready, rd_req_o=0 and there is no deadlock once space returns.
- op_req_valid_i in BUSY is ignored (ready=0); the upstream holds the request.
- idx never exceeds RegWords*8 (LMUL 8). Larger acc_cnt is an upstream error; covered by an assertion, behaviour otherwise undefined.

Decomposition:
- Add to core_pkg:
  - typedef op_rd_req_t {vrf_addr_t addr; op_queue_e queue;}
  - GetOpSrcReg(op_queue_e), mapping each queue to vs1 or vs2.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], gnt_accept, pointer update.
  - Outputs: one-hot grant and index.
  - Reused later by the bank arbiter.

Test Plan:
- Single ALUA request, vs1=3, acc_cnt=4, ready/gnt always 1 -> four reads at addrs GetVRFAddr(3)+0..3, tag ALUA, consecutive cycles; op_done_o one cycle after the 4th grant.
- ALUA+ALUB, vs1=1, vs2=2, acc_cnt=2 -> reads alternate ALUA, ALUB, ALUA, ALUB (addrs base1+0, base2+0, base1+1, base2+1); done after 4 grants.
- Same as previous with queue_ready_i[ALUB]=0 for 5 cycles -> both ALUA reads issue first, ALUB resumes when ready rises; no lost or duplicated index.
- rd_gnt_i held 0 for 3 cycles mid-stream -> rd_req_o stays 1, idx unchanged, no done until all 4 grants.
- Request with acc_cnt=0 -> no rd_req_o; op_done_o pulses next cycle; ready stays 1.
- rst_ni low during BUSY after 2 of 4 reads -> outputs at reset values next cycle; no op_done_o; a new request restarts at idx 0.
